// File: rtl/dvs_event_packetizer.sv
// DVS event packetizer: timestamps camera events, buffers them in a FIFO and
// serialises each into NPKT packets. Optional macro: DVS_PACKETIZER_DROP_CNT_EN adds drop_count.
module dvs_event_packetizer #(
    parameter int X_BITS   = 9,
    parameter int Y_BITS   = 9,
    parameter int TS_BITS  = 47,
    parameter int CLK_DIV  = 100,
    parameter int PKT_BITS = 32,
    parameter int DEPTH    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_valid,
    input  logic [X_BITS-1:0]        ev_x,
    input  logic [Y_BITS-1:0]        ev_y,
    input  logic                     ev_pol,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [PKT_BITS-1:0]      pkt_data,
    output logic                     pkt_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
`ifdef DVS_PACKETIZER_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic [TS_BITS-1:0]       ts_now
);

    localparam int EVENT_BITS = X_BITS + Y_BITS + 1 + TS_BITS;
    localparam int NPKT       = (EVENT_BITS + PKT_BITS - 1) / PKT_BITS;
    localparam int WORD_BITS  = NPKT * PKT_BITS;
    localparam int AW         = $clog2(DEPTH);
    localparam int LW         = AW + 1;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W      = (NPKT > 1) ? $clog2(NPKT) : 1;

    localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NPKT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // ------------------------------------------------------------------
    // Microsecond timestamp
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]   div_reg;
    logic [TS_BITS-1:0] ts_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= '0;
            ts_reg  <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            ts_reg  <= ts_reg + TS_BITS'(1);
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic [LW-1:0]        level_next;
    logic [WORD_BITS-1:0] ev_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    assign fifo_full  = (level_reg == FULL_LEVEL);
    assign fifo_empty = (level_reg == '0);
    // The camera cannot be stalled: fullness is judged on the level at the
    // start of the cycle, so a same-cycle pop never rescues an event.
    assign push       = ev_valid && !fifo_full;
    assign ev_word    = WORD_BITS'({ev_x, ev_y, ev_pol, ts_reg});

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= ev_word;
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    logic [0:0]           state_reg;
    logic [0:0]           state_next;
    logic [IDX_W-1:0]     idx_reg;
    logic [IDX_W-1:0]     idx_next;
    logic [WORD_BITS-1:0] word_reg;
    logic [PKT_BITS-1:0]  pkt_slice [NPKT];

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    idx_next   = '0;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pkt_ready) begin
                    if (idx_reg == IDX_LAST) begin
                        // Reload straight from the FIFO so events stream without a bubble.
                        if (!fifo_empty) begin
                            pop      = 1'b1;
                            idx_next = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Registered read of the FIFO head doubles as the event holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg <= '0;
        end else if (pop) begin
            word_reg <= mem[rd_ptr_reg];
        end
    end

    generate
        for (genvar gi = 0; gi < NPKT; gi++) begin : g_slice
            assign pkt_slice[gi] = word_reg[WORD_BITS-1-gi*PKT_BITS -: PKT_BITS];
        end
    endgenerate

    assign pkt_valid  = (state_reg == ST_SEND);
    assign pkt_data   = (state_reg == ST_SEND) ? pkt_slice[idx_reg] : '0;
    assign pkt_last   = (state_reg == ST_SEND) && (idx_reg == IDX_LAST);
    assign fifo_level = level_reg;
    assign ts_now     = ts_reg;

`ifdef DVS_PACKETIZER_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (ev_valid && fifo_full && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_count = drop_cnt_reg;
`endif

endmodule
